// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access unit: RV32 funct3 load/store sizes,
// FSM states and the helpers that classify an access by size.
package mem_access_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam int MAX_RD_LAT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Any store funct3 other than SB/SH is handled as a full-word store.
    function automatic logic is_word_store(input logic [2:0] op);
        return (op != OP_B) && (op != OP_H);
    endfunction

    function automatic logic is_misaligned(input logic we, input logic [2:0] op,
                                           input logic [1:0] lo);
        logic is_byte;
        logic is_half;
        is_byte = (op == OP_B) || (!we && (op == OP_BU));
        is_half = (op == OP_H) || (!we && (op == OP_HU));
        if (is_byte) return 1'b0;
        if (is_half) return lo[0];
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Bundle of the CPU request/response channels and the word-addressed memory port.
// Request and response use valid/ready: a transfer happens on a rising edge where both are 1;
// the sender keeps valid and payload stable until then.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_write;
    logic        mem_read;

    modport master (
        input  req_valid, req_op, req_we, req_addr, req_wdata, rsp_ready, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_address, mem_write_data, mem_write, mem_read
    );

    modport slave (
        output req_valid, req_op, req_we, req_addr, req_wdata, rsp_ready, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_address, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extracts/extends load data from a memory word and merges
// sub-word store data into a sampled word. Purely combinational.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(word_i >> {addr_lo_i, 3'b000});
    assign half_v = 16'(word_i >> {addr_lo_i[1], 4'b0000});

    always_comb begin
        load_data_o  = word_i;
        store_word_o = wdata_i;
        case (op_i)
            OP_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
            OP_H:    load_data_o = {{16{half_v[15]}}, half_v};
            OP_BU:   load_data_o = {24'h0, byte_v};
            OP_HU:   load_data_o = {16'h0, half_v};
            default: load_data_o = word_i;
        endcase
        case (op_i)
            OP_B: begin
                store_word_o = word_i;
                store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            OP_H: begin
                store_word_o = word_i;
                store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory; sub-word stores use read-modify-write.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses with rsp_err instead of masking.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int MEM_RD_LAT = 1
) (
    input  logic         clock,
    input  logic         reset,
    mem_access_if.master bus,
    output state_e       dbg_state_o
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [2:0] LAST_RD = 3'(MEM_RD_LAT - 1);

    state_e              state_q, state_d;
    logic [2:0]          rd_cnt_q, rd_cnt_d;
    logic [2:0]          op_q, op_d;
    logic                we_q, we_d;
    logic [1:0]          lo_q, lo_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [31:0]         load_data;
    logic [31:0]         store_word;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    mem_lane_align u_align (
        .op_i         (op_q),
        .addr_lo_i    (lo_q),
        .word_i       (bus.mem_read_data),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_cnt_q    <= 3'd0;
            op_q        <= 3'd0;
            we_q        <= 1'b0;
            lo_q        <= 2'd0;
            widx_q      <= '0;
            wdata_q     <= 32'h0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            op_q        <= op_d;
            we_q        <= we_d;
            lo_q        <= lo_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        op_d        = op_q;
        we_d        = we_q;
        lo_d        = lo_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    we_d     = bus.req_we;
                    lo_d     = bus.req_addr[1:0];
                    widx_d   = bus.req_addr[ADDR_W+1:2];
                    wdata_d  = bus.req_wdata;
                    rd_cnt_d = 3'd0;
                    err_d    = 1'b0;
                    if (TRAP_EN && is_misaligned(bus.req_we, bus.req_op, bus.req_addr[1:0])) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = RESP;
                    end else if (bus.req_we && is_word_store(bus.req_op)) begin
                        mem_wdata_d = bus.req_wdata;
                        state_d     = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // Memory data is only valid on the last cycle of the read window.
                if (rd_cnt_q == LAST_RD) begin
                    if (we_q) begin
                        mem_wdata_d = store_word;
                        state_d     = WRITE;
                    end else begin
                        rdata_d = load_data;
                        state_d = RESP;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                end
            end
            WRITE: begin
                rdata_d = 32'h0;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.rsp_valid      = (state_q == RESP);
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_err        = TRAP_EN & err_q;
    assign bus.mem_address    = {{(32-ADDR_W){1'b0}}, widx_q};
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_write      = (state_q == WRITE);
    assign bus.mem_read       = (state_q == READ);
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural 32-word memory with read latency, directed
// cases followed by random loads/stores checked against an arithmetic reference model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int LAT = 1;
    localparam int AW  = 5;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic   clock;
    logic   reset;
    state_e dbg_state;
    mem_access_if bus ();

    mem_access_unit #(.ADDR_W(AW), .MEM_RD_LAT(LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic [31:0] exp_q [$];
    logic        poke_en;
    logic [4:0]  poke_idx;
    logic [31:0] poke_val;
    int          rd_cyc;
    int          wr_cnt;
    int          rd_cnt;
    int          both_cnt;
    logic [31:0] last_wr_addr;
    int          n_checks;
    int          n_errors;

    always @(posedge clock or negedge reset) begin
        if (!reset) rd_cyc <= 0;
        else        rd_cyc <= bus.mem_read ? rd_cyc + 1 : 0;
    end

    always @(posedge clock) begin
        if (bus.mem_write) begin
            mem[bus.mem_address[4:0]] <= bus.mem_write_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.mem_address;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_val;
        end
        if (bus.mem_read) rd_cnt <= rd_cnt + 1;
        if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
    end

    assign bus.mem_read_data = (bus.mem_read && rd_cyc == LAT - 1) ?
                               mem[bus.mem_address[4:0]] : 32'hA5A5_5A5A;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic we, input logic [2:0] op);
        if (op == 3'b000 || (!we && op == 3'b100)) return 1;
        if (op == 3'b001 || (!we && op == 3'b101)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] word);
        int          sz;
        logic [31:0] v;
        sz = acc_size(1'b0, op);
        if (sz == 4) return word;
        if (sz == 2) begin
            v = (word >> (16 * ((addr >> 1) % 2))) & 32'hFFFF;
            if (op == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            return v;
        end
        v = (word >> (8 * (addr % 4))) & 32'hFF;
        if (op == 3'b000 && v >= 32'h80) v = v + 32'hFFFF_FF00;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] op, input logic [31:0] addr,
                                                input logic [31:0] old, input logic [31:0] wdata);
        int          sz;
        int          sh;
        logic [31:0] mask;
        sz = acc_size(1'b1, op);
        if (sz == 4) return wdata;
        sh   = (sz == 2) ? 16 * ((addr >> 1) % 2) : 8 * (addr % 4);
        mask = (sz == 2) ? 32'hFFFF : 32'hFF;
        return (old & ~(mask << sh)) | ((wdata & mask) << sh);
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clock);
        poke_en  = 1'b1;
        poke_idx = 5'(idx);
        poke_val = val;
        ref_mem[idx] = val;
        @(negedge clock);
        poke_en = 1'b0;
    endtask

    // One request from IDLE through response release; stall > 0 holds rsp_ready low that long
    // while another request is offered and must be ignored.
    task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall);
        int          idx, j, wr0, rd0, sz, exp_lat, exp_rd, exp_wr;
        logic        exp_err, addr_bad, ok;
        logic [31:0] new_word, first;
        idx     = int'((addr >> 2) % 32);
        sz      = acc_size(we, op);
        exp_err = TRAP && ((addr % sz) != 0);
        if (exp_err) begin
            exp_q.push_back(32'h0);
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_q.push_back(model_load(op, addr, ref_mem[idx]));
            exp_lat = LAT + 1; exp_rd = LAT; exp_wr = 0;
        end else begin
            exp_q.push_back(32'h0);
            exp_lat = (sz == 4) ? 2 : LAT + 2;
            exp_rd  = (sz == 4) ? 0 : LAT;
            exp_wr  = 1;
        end
        new_word = (we && !exp_err) ? model_store(op, addr, ref_mem[idx], wdata) : ref_mem[idx];

        @(negedge clock);
        check_val("req_ready_idle", 32'(bus.req_ready), 32'd1);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_op    = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        j = 1;
        addr_bad = 1'b0;
        while (!bus.rsp_valid && j < 40) begin
            if ((bus.mem_read || bus.mem_write) && bus.mem_address != 32'(idx)) addr_bad = 1'b1;
            @(negedge clock);
            j++;
        end
        check_val("rsp_latency", 32'(j), 32'(exp_lat));
        check_val("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
        check_val("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check_val("mem_address", 32'(addr_bad), 32'd0);

        if (stall > 0) begin
            first = bus.rsp_rdata;
            ok    = 1'b1;
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_op    = OP_W;
            bus.req_addr  = 32'h1C;
            for (int k = 0; k < stall; k++) begin
                @(negedge clock);
                if (!bus.rsp_valid || bus.rsp_rdata !== first || bus.req_ready ||
                    bus.mem_read || bus.mem_write) ok = 1'b0;
            end
            check_val("stall_hold", 32'(ok), 32'd1);
            bus.req_valid = 1'b0;
        end

        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check_val("rsp_release", 32'(bus.rsp_valid), 32'd0);
        check_val("ready_after_resp", 32'(bus.req_ready), 32'd1);
        @(negedge clock);
        check_val("rd_cycles", 32'(rd_cnt - rd0), 32'(exp_rd));
        check_val("wr_strobes", 32'(wr_cnt - wr0), 32'(exp_wr));
        ref_mem[idx] = new_word;
        check_val("mem_word", mem[idx], ref_mem[idx]);
        if (exp_wr == 1) check_val("wr_addr", last_wr_addr, 32'(idx));
    endtask

    // Reset asserted while an SH sits in its read window: no write may ever land.
    task automatic reset_mid_sh();
        int wr0;
        wr0 = wr_cnt;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_op    = OP_H;
        bus.req_addr  = 32'h16;
        bus.req_wdata = 32'h0000_7777;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check_val("sh_in_read", 32'(bus.mem_read), 32'd1);
        reset = 1'b0;
        #1;
        check_val("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check_val("rst_mem_write", 32'(bus.mem_write), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check_val("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
        check_val("rst_mem_kept", mem[5], ref_mem[5]);
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        poke_en       = 1'b0;
        poke_idx      = 5'd0;
        poke_val      = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        reset         = 1'b1;
        #2 reset      = 1'b0;

        for (int i = 0; i < 32; i++) poke(i, $urandom);
        poke(3, 32'h8899_AABB);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_val("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_val("reset_strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        check_val("reset_mem_address", bus.mem_address, 32'h0);
        check_val("reset_mem_wdata", bus.mem_write_data, 32'h0);

        run_txn(1'b0, OP_B,  32'h0D, 32'h0, 0);
        run_txn(1'b0, OP_BU, 32'h0D, 32'h0, 0);
        run_txn(1'b0, OP_H,  32'h0E, 32'h0, 0);
        run_txn(1'b1, OP_B,  32'h0D, 32'h1234_56CC, 0);
        check_val("sb_merge", mem[3], 32'h8899_CCBB);
        run_txn(1'b1, OP_W,  32'h10, 32'hDEAD_BEEF, 0);
        check_val("sw_word", mem[4], 32'hDEAD_BEEF);
        run_txn(1'b0, OP_W,  32'h0E, 32'h0, 0);
        run_txn(1'b0, OP_W,  32'hFFFF_FF8C, 32'h0, 0);
        run_txn(1'b0, OP_HU, 32'h12, 32'h0, 5);
        run_txn(1'b1, OP_H,  32'h1B, 32'hABCD_9876, 0);
        reset_mid_sh();

        for (int n = 0; n < 150; n++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    ($urandom_range(0, 9) == 0) ? 3 : 0);
        end

        for (int i = 0; i < 32; i++) check_val("final_mem", mem[i], ref_mem[i]);
        check_val("strobe_overlap", 32'(both_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
